// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe game controller: cell codes,
// FSM state codes, winning-line bit positions and the cursor-step helper.
package ttt_pkg;

    localparam int BOARD_W   = 18;
    localparam int NUM_CELLS = 9;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_P_MOVE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_WIN    = 3'd3;
    localparam logic [2:0] ST_DRAW   = 3'd4;

    localparam int LINE_ROW0 = 0;
    localparam int LINE_ROW1 = 1;
    localparam int LINE_ROW2 = 2;
    localparam int LINE_COL0 = 3;
    localparam int LINE_COL1 = 4;
    localparam int LINE_COL2 = 5;
    localparam int LINE_DIAG = 6;
    localparam int LINE_ANTI = 7;

    // One cursor step on the 3x3 grid, wrapping inside the row/column.
    // Priority up > down > left > right.
    function automatic logic [3:0] cursor_step(input logic [3:0] cur,
                                               input logic up,
                                               input logic down,
                                               input logic left,
                                               input logic right);
        logic [1:0] col;
        logic [3:0] nxt;
        case (cur)
            4'd0, 4'd3, 4'd6: col = 2'd0;
            4'd1, 4'd4, 4'd7: col = 2'd1;
            default:          col = 2'd2;
        endcase
        nxt = cur;
        if (up)
            nxt = (cur < 4'd3) ? cur + 4'd6 : cur - 4'd3;
        else if (down)
            nxt = (cur >= 4'd6) ? cur - 4'd6 : cur + 4'd3;
        else if (left)
            nxt = (col == 2'd0) ? cur + 4'd2 : cur - 4'd1;
        else if (right)
            nxt = (col == 2'd2) ? cur - 4'd2 : cur + 4'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line detector: flags every row/column/diagonal fully
// occupied by the given mark. An empty mark never matches.
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board_i,
    input  logic [1:0]         mark_i,
    output logic [7:0]         win_line_o,
    output logic               any_win_o
);

    logic [NUM_CELLS-1:0] own;

    // Per-cell ownership by the mark under test
    always_comb begin
        own = '0;
        for (int i = 0; i < NUM_CELLS; i++)
            own[i] = (mark_i != CELL_EMPTY) && (board_i[2*i +: 2] == mark_i);
    end

    assign win_line_o[LINE_ROW0] = own[0] & own[1] & own[2];
    assign win_line_o[LINE_ROW1] = own[3] & own[4] & own[5];
    assign win_line_o[LINE_ROW2] = own[6] & own[7] & own[8];
    assign win_line_o[LINE_COL0] = own[0] & own[3] & own[6];
    assign win_line_o[LINE_COL1] = own[1] & own[4] & own[7];
    assign win_line_o[LINE_COL2] = own[2] & own[5] & own[8];
    assign win_line_o[LINE_DIAG] = own[0] & own[4] & own[8];
    assign win_line_o[LINE_ANTI] = own[2] & own[4] & own[6];
    assign any_win_o             = |win_line_o;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: cursor movement, mark placement for
// alternating players, win/draw detection and registered status outputs.
// Optional per-move forfeit timer enabled by defining TTT_MOVE_TIMEOUT_EN.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
    parameter logic [3:0]  START_CURSOR   = 4'd4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_sel,
    output logic [BOARD_W-1:0] board,
    output logic [3:0]         cursor,
    output logic               turn,
    output logic               game_active,
    output logic               player_1_win,
    output logic               player_2_win,
    output logic               draw,
    output logic [7:0]         win_line,
    output logic               illegal,
    output logic               timeout
);

    logic [2:0]         state_q, state_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic [3:0]         cursor_q, cursor_d;
    logic               turn_q, turn_d;
    logic [3:0]         move_cnt_q, move_cnt_d;
    logic               p1_win_q, p1_win_d;
    logic               p2_win_q, p2_win_d;
    logic               draw_q, draw_d;
    logic [7:0]         win_line_q, win_line_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;

    logic [1:0] cur_cell;
    logic [1:0] mark;
    logic [7:0] chk_lines;
    logic       chk_any;

    assign cur_cell = board_q[{cursor_q, 1'b0} +: 2];
    assign mark     = turn_q ? CELL_O : CELL_X;

    // Evaluated against the mark just placed; only consulted in CHECK
    ttt_win_check u_win_check (
        .board_i    (board_q),
        .mark_i     (mark),
        .win_line_o (chk_lines),
        .any_win_o  (chk_any)
    );

`ifdef TTT_MOVE_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
`else
    // Parameter retained so both builds share one instantiation interface
    logic tmo_unused;
    assign tmo_unused = ^TIMEOUT_CYCLES;
`endif

    // Next-state logic for the game FSM and all registered outputs
    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        cursor_d   = cursor_q;
        turn_d     = turn_q;
        move_cnt_d = move_cnt_q;
        p1_win_d   = p1_win_q;
        p2_win_d   = p2_win_q;
        draw_d     = draw_q;
        win_line_d = win_line_q;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;
`ifdef TTT_MOVE_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_WIN, ST_DRAW: begin
                if (start) begin
                    state_d    = ST_P_MOVE;
                    board_d    = '0;
                    cursor_d   = START_CURSOR;
                    turn_d     = 1'b0;
                    move_cnt_d = 4'd0;
                    p1_win_d   = 1'b0;
                    p2_win_d   = 1'b0;
                    draw_d     = 1'b0;
                    win_line_d = '0;
`ifdef TTT_MOVE_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                end
            end
            ST_P_MOVE: begin
                if (btn_sel && cur_cell == CELL_EMPTY) begin
                    board_d[{cursor_q, 1'b0} +: 2] = mark;
                    move_cnt_d = (move_cnt_q == 4'd9) ? 4'd9 : move_cnt_q + 4'd1;
                    state_d    = ST_CHECK;
                end else begin
                    if (btn_sel)
                        illegal_d = 1'b1;
                    else
                        cursor_d = cursor_step(cursor_q, btn_up, btn_down,
                                               btn_left, btn_right);
`ifdef TTT_MOVE_TIMEOUT_EN
                    // Forfeit the move: hand the turn over, board untouched
                    if (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                        timeout_d = 1'b1;
                        turn_d    = ~turn_q;
                        tmo_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 32'd1;
                    end
`endif
                end
            end
            ST_CHECK: begin
                if (chk_any) begin
                    state_d    = ST_WIN;
                    p1_win_d   = ~turn_q;
                    p2_win_d   = turn_q;
                    win_line_d = chk_lines;
                end else if (move_cnt_q == 4'd9) begin
                    state_d = ST_DRAW;
                    draw_d  = 1'b1;
                end else begin
                    state_d = ST_P_MOVE;
                    turn_d  = ~turn_q;
`ifdef TTT_MOVE_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; clr overrides every other input
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            board_q    <= '0;
            cursor_q   <= START_CURSOR;
            turn_q     <= 1'b0;
            move_cnt_q <= 4'd0;
            p1_win_q   <= 1'b0;
            p2_win_q   <= 1'b0;
            draw_q     <= 1'b0;
            win_line_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef TTT_MOVE_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            cursor_q   <= cursor_d;
            turn_q     <= turn_d;
            move_cnt_q <= move_cnt_d;
            p1_win_q   <= p1_win_d;
            p2_win_q   <= p2_win_d;
            draw_q     <= draw_d;
            win_line_q <= win_line_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
`ifdef TTT_MOVE_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    assign board        = board_q;
    assign cursor       = cursor_q;
    assign turn         = turn_q;
    assign game_active  = (state_q == ST_P_MOVE) || (state_q == ST_CHECK);
    assign player_1_win = p1_win_q;
    assign player_2_win = p2_win_q;
    assign draw         = draw_q;
    assign win_line     = win_line_q;
    assign illegal      = illegal_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: stimulus queues expected output
// snapshots tagged with the cycle they are due; a monitor compares them.
module tb_ttt_game_ctrl;

    localparam logic [6:0] B_SEL   = 7'b0000001;
    localparam logic [6:0] B_RIGHT = 7'b0000010;
    localparam logic [6:0] B_LEFT  = 7'b0000100;
    localparam logic [6:0] B_DOWN  = 7'b0001000;
    localparam logic [6:0] B_UP    = 7'b0010000;
    localparam logic [6:0] B_START = 7'b0100000;
    localparam logic [6:0] B_CLR   = 7'b1000000;

    logic        clk = 1'b0;
    logic        clr, start, btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [17:0] board;
    logic [3:0]  cursor;
    logic        turn, game_active, player_1_win, player_2_win, draw;
    logic [7:0]  win_line;
    logic        illegal, timeout;

    always #5 clk = ~clk;

    ttt_game_ctrl #(
        .TIMEOUT_CYCLES (32'd16),
        .START_CURSOR   (4'd4)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_sel      (btn_sel),
        .board        (board),
        .cursor       (cursor),
        .turn         (turn),
        .game_active  (game_active),
        .player_1_win (player_1_win),
        .player_2_win (player_2_win),
        .draw         (draw),
        .win_line     (win_line),
        .illegal      (illegal),
        .timeout      (timeout)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    string       q_name[$];
    int          q_due[$];
    logic [36:0] q_exp[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cur;

    function automatic logic [36:0] observed();
        return {board, cursor, turn, game_active, player_1_win, player_2_win,
                draw, win_line, illegal, timeout};
    endfunction

    // Monitor: compare every snapshot due at this cycle
    initial begin
        forever begin
            @(negedge clk);
            while (q_due.size() > 0 && q_due[0] <= cyc) begin
                n_chk++;
                if (q_due[0] < cyc) begin
                    n_err++;
                    $display("FAIL %s: snapshot missed, due cycle %0d now %0d",
                             q_name[0], q_due[0], cyc);
                end else if (observed() !== q_exp[0]) begin
                    n_err++;
                    $display("FAIL %s: got {board,cur,turn,act,p1,p2,draw,wl,ill,tmo}=%h required %h",
                             q_name[0], observed(), q_exp[0]);
                end
                void'(q_name.pop_front());
                void'(q_due.pop_front());
                void'(q_exp.pop_front());
            end
        end
    end

    task automatic expect_st(input string nm, input logic [17:0] b, input logic [3:0] cu,
                             input logic t, input logic a, input logic p1, input logic p2,
                             input logic dr, input logic [7:0] wl, input logic il,
                             input logic tm);
        q_name.push_back(nm);
        q_due.push_back(cyc);
        q_exp.push_back({b, cu, t, a, p1, p2, dr, wl, il, tm});
    endtask

    // Apply one cycle of inputs {clr,start,up,down,left,right,sel}
    task automatic drive(input logic [6:0] v);
        {clr, start, btn_up, btn_down, btn_left, btn_right, btn_sel} = v;
        @(posedge clk);
        #1;
        {clr, start, btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_cell(input int t);
        while (cur % 3 != t % 3) begin
            drive(B_RIGHT);
            cur = (cur / 3) * 3 + ((cur % 3) + 1) % 3;
        end
        while (cur / 3 != t / 3) begin
            drive(B_DOWN);
            cur = (cur + 3) % 9;
        end
    endtask

    task automatic place(input int t);
        goto_cell(t);
        drive(B_SEL);
        idle(1);
    endtask

    initial begin
        {clr, start, btn_up, btn_down, btn_left, btn_right, btn_sel} = 7'b1000000;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        expect_st("reset", 18'h0, 4'd4, 0, 0, 0, 0, 0, 8'h00, 0, 0);

        // Player 1 wins along row 0
        drive(B_START); cur = 4;
        expect_st("start", 18'h0, 4'd4, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        place(0); place(3); place(1); place(4);
        goto_cell(2);
        drive(B_SEL);
        expect_st("win_check_cycle", 18'h00295, 4'd2, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        idle(1);
        expect_st("p1_win", 18'h00295, 4'd2, 0, 0, 1, 0, 0, 8'h01, 0, 0);
        drive(B_UP);
        expect_st("win_ignores_btn", 18'h00295, 4'd2, 0, 0, 1, 0, 0, 8'h01, 0, 0);
        drive(B_START); cur = 4;
        expect_st("restart_from_win", 18'h0, 4'd4, 0, 1, 0, 0, 0, 8'h00, 0, 0);

        // Full board, no line
        place(0); place(1); place(2); place(4);
        expect_st("mid_draw", 18'h00219, 4'd4, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        place(3); place(5); place(7); place(6); place(8);
        expect_st("draw", 18'h16A59, 4'd8, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        n_chk++;
        if (dut.move_cnt_q !== 4'd9) begin
            n_err++;
            $display("FAIL move_cnt: got %0d required 9", dut.move_cnt_q);
        end

        // Select on an occupied cell
        drive(B_START); cur = 4;
        drive(B_SEL);
        idle(1);
        expect_st("first_sel", 18'h00100, 4'd4, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        drive(B_SEL);
        expect_st("illegal_pulse", 18'h00100, 4'd4, 1, 1, 0, 0, 0, 8'h00, 1, 0);
        idle(1);
        expect_st("illegal_clears", 18'h00100, 4'd4, 1, 1, 0, 0, 0, 8'h00, 0, 0);

        // Cursor wrapping and priority
        drive(B_UP);
        drive(B_RIGHT);
        expect_st("cursor_at_2", 18'h00100, 4'd2, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        drive(B_RIGHT);
        expect_st("right_wrap", 18'h00100, 4'd0, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        drive(B_UP);
        expect_st("up_wrap", 18'h00100, 4'd6, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        drive(B_UP | B_LEFT);
        expect_st("up_beats_left", 18'h00100, 4'd3, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        drive(B_DOWN);
        drive(B_DOWN);
        expect_st("down_wrap", 18'h00100, 4'd0, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        drive(B_LEFT);
        expect_st("left_wrap", 18'h00100, 4'd2, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        drive(B_START);
        expect_st("start_ignored", 18'h00100, 4'd2, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        drive(B_SEL | B_UP);
        expect_st("sel_beats_dir", 18'h00120, 4'd2, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        idle(1);
        expect_st("turn_back_p1", 18'h00120, 4'd2, 0, 1, 0, 0, 0, 8'h00, 0, 0);

        // clr mid-game beats a simultaneous start
        drive(B_CLR | B_START);
        expect_st("clr_midgame", 18'h0, 4'd4, 0, 0, 0, 0, 0, 8'h00, 0, 0);

        // Idle in P_MOVE long enough to forfeit when the timer exists
        drive(B_START); cur = 4;
        idle(15);
        expect_st("no_timeout_yet", 18'h0, 4'd4, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        idle(1);
`ifdef TTT_MOVE_TIMEOUT_EN
        expect_st("timeout_pulse", 18'h0, 4'd4, 1, 1, 0, 0, 0, 8'h00, 0, 1);
        idle(1);
        expect_st("timeout_clears", 18'h0, 4'd4, 1, 1, 0, 0, 0, 8'h00, 0, 0);
`else
        expect_st("no_timeout_feature", 18'h0, 4'd4, 0, 1, 0, 0, 0, 8'h00, 0, 0);
`endif

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && q_due.size() > 0; i++) @(negedge clk);
        if (q_due.size() > 0) begin
            n_chk += q_due.size();
            n_err += q_due.size();
            $display("FAIL drain: %0d snapshots never compared", q_due.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Game sequencer for the tic-tac-toe board. It takes single-cycle button pulses, moves a selection cursor and places X/O marks for alternating players, and detects win/draw. It exports the 9-cell board state and status flags to the VGA renderer, which draws the grid, marks and cursor from these outputs.

Parameters:
TIMEOUT_CYCLES, 32'd250_000_000, cycles allowed per move before forfeit (timeout feature only)
START_CURSOR, 4'd4, cursor cell index after reset/new game (0..8, row-major)

Ports:
clk  in  1  system clock
clr  in  1  reset, synchronous, active-high
start  in  1  pulse: begin new game (honoured only in IDLE, WIN, DRAW)
btn_up  in  1  pulse: cursor up
btn_down  in  1  pulse: cursor down
btn_left  in  1  pulse: cursor left
btn_right  in  1  pulse: cursor right
btn_sel  in  1  pulse: place current player's mark at cursor
board  out  18  cell i = board[2i+1:2i]; 00 empty, 01 X (player 1), 10 O (player 2)
cursor  out  4  selected cell 0..8
turn  out  1  0 = player 1 to move, 1 = player 2
game_active  out  1  high in P_MOVE/CHECK states
player_1_win  out  1  level, high in WIN when player 1 won
player_2_win  out  1  level, high in WIN when player 2 won
draw  out  1  level, high in DRAW
win_line  out  8  one-hot winning line (rows 0-2, cols 3-5, diag 6, anti-diag 7); 0 otherwise
illegal  out  1  one-cycle pulse: select on occupied cell
timeout  out  1  one-cycle pulse: move forfeited (0 when feature absent)

Behaviour:
- Inputs are already synchronised, debounced, one-cycle pulses.
- States: IDLE, P_MOVE, CHECK, WIN, DRAW. Reset (clr=1 at posedge): state IDLE, board 0, cursor START_CURSOR, turn 0, move_cnt 0, all flags/pulses 0, win_line 0. clr overrides every other input, mid-game included.
- IDLE/WIN/DRAW + start: next cycle board cleared, move_cnt 0, turn 0, cursor START_CURSOR, flags cleared, state P_MOVE. Button pulses ignored in these states.
- P_MOVE, cursor: priority up > down > left > right; one step per cycle. Wrap within row/column: up from row 0 -> row 2, right from col 2 -> col 0, etc.
- P_MOVE + btn_sel, cell empty: next cycle cell = (turn ? 10 : 01), move_cnt+1, state CHECK; any same-cycle direction pulse ignored. Cell occupied: board unchanged, illegal high for exactly that next cycle, stay P_MOVE.
- CHECK (exactly 1 cycle): win found for mark just placed -> WIN, matching flag and win_line set next cycle (several lines complete: all bits set). Else move_cnt==9 -> DRAW. Else turn toggles, -> P_MOVE. Select-to-flag latency: 2 cycles.
- start during P_MOVE/CHECK ignored.
- move_cnt is 4-bit internal, saturates at 9.
- Outputs registered; board/flags stable between transitions.

Optional Feature:
TTT_MOVE_TIMEOUT_EN
- Defined: counter cleared on every entry to P_MOVE. When it reaches TIMEOUT_CYCLES-1 without a legal select, timeout pulses 1 cycle, turn toggles, counter clears, state stays P_MOVE, board unchanged. A legal select in the same cycle wins over timeout. Cursor moves do not reset the counter.
- Undefined: no counter synthesised; timeout tied 0.

Decomposition:
- Package ttt_pkg: cell encodings (CELL_EMPTY, CELL_X, CELL_O), state encoding, line index constants, BOARD_W=18.
- Sub-module ttt_win_check: combinational; inputs board plus a 2-bit mark; outputs 8-bit win_line and any_win. The controller instantiates it once, in CHECK.

Test Plan:
- clr, start; P1 selects 0,1,2 and P2 selects 3,4 (moving the cursor between turns) -> after 5th placement + 2 cycles player_1_win=1, win_line=8'b0000_0001, state WIN.
- Fill the board in draw order X0 O1 X2 O4 X3 O5 X7 O6 X8 -> draw=1, no win flag, move_cnt 9.
- Select cell 4 twice (P1, then P2 on same cell) -> illegal pulses 1 cycle, board[9:8]=01, turn stays 1.
- Cursor at 2, btn_right -> 0; at 0, btn_up -> 6; btn_up+btn_left same cycle -> only the up move is applied.
- clr asserted mid-game with board non-empty -> next cycle board=0, IDLE, cursor=4; start without clr from WIN -> new game, turn=0.
- With TTT_MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=16: idle 16 cycles in P_MOVE -> timeout pulse, turn 0->1, board unchanged.
